instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 imem_addr  output  32  instruction memory address; always equals pc.
REQ-005 imem_req  output  1  fetch request; high only in RUN state with stall low.
REQ-006 imem_rdata  input  32  instruction word; valid when imem_req and imem_ready are both high in the same cycle.
REQ-007 imem_ready  input  1  memory acknowledge; a fetch is accepted only when imem_req and imem_ready are high together.
REQ-008 stall  input  1  hazard hold from decode; freezes pc and the IF/ID register.
REQ-009 branch_taken  input  1  redirect to branch_target.
REQ-010 branch_target  input  32  full branch target address.
REQ-011 jump  input  1  redirect to the jump target.
REQ-012 jump_index  input  26  J-type instr_index field.
REQ-013 halt  input  1  stop fetching until reset.
REQ-014 if_instr  output  32  IF/ID instruction register.
REQ-015 if_pc4  output  32  IF/ID register holding the PC+4 of the captured instruction.
REQ-016 if_valid  output  1  if_instr holds a live instruction.
REQ-017 opcode  output  6  if_instr[31:26]; feeds the main control decoder.
REQ-018 instr_count  output  32  count of accepted fetches.
REQ-019 align_err  output  1  sticky flag for a misaligned redirect target.

Function
REQ-020 The FSM SHALL have three states: BOOT, RUN and HALTED. BOOT moves to RUN after one cycle. RUN moves to HALTED when halt is high. HALTED is left only by reset.
REQ-021 In BOOT and HALTED, imem_req SHALL be 0, pc SHALL hold, and if_valid SHALL be 0.
REQ-022 An accepted fetch (RUN, stall low, imem_ready high, no redirect) SHALL do the following next edge: if_instr<=imem_rdata, if_pc4<=pc+4, if_valid<=1, pc<=pc+4, instr_count+=1.
REQ-023 In RUN with stall low, imem_ready low and no redirect, the block SHALL hold pc and set if_valid<=0 (bubble).
REQ-024 When stall is high and no redirect is present, pc, if_instr, if_pc4 and if_valid SHALL hold, and imem_req SHALL be 0.
REQ-025 On a redirect, the block SHALL do the following next edge, regardless of stall or imem_ready: pc<=target, if_valid<=0, no capture, no count.
REQ-026 Redirect priority SHALL be jump over branch_taken.
REQ-027 The jump target SHALL be {if_pc4[31:28], jump_index, 2'b00}.
REQ-028 The branch target SHALL be {branch_target[31:2], 2'b00}.
REQ-029 A branch_taken redirect with branch_target[1:0]!=0 SHALL set align_err, which stays set until reset.
REQ-030 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-032 Redirects and accepted fetches SHALL be ignored in HALTED.
REQ-033 If halt and a redirect occur in the same cycle, halt SHALL win: pc holds.
REQ-034 The fetch latency SHALL be zero wait states when imem_ready is high. The captured instruction SHALL be visible on if_instr and opcode on the cycle after acceptance.

Reset
REQ-035 While rst is high, the block SHALL asynchronously set: state=BOOT, pc=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, instr_count=0, align_err=0.
REQ-036 The resulting reset outputs SHALL be: imem_req=0, imem_addr=RESET_PC, opcode=0.
REQ-037 Reset asserted mid-fetch SHALL abandon the transaction with no capture. The first fetch after reset SHALL occur one cycle after the BOOT cycle.

Structure
REQ-038 Shared package mips_pkg SHALL hold: the opcode constants (R_TYPE, ADDI, LW, SW, BEQ, BNE, J) shared with the control decoder, the fetch-state enum, and the default RESET_PC constant.
REQ-039 The next-PC selection (pc+4 / branch / jump, with priority and alignment) SHALL be one combinational sub-module, pc_next. The FSM, pc and IF/ID registers SHALL stay in instr_fetch.

Verification
REQ-040 Reset with imem_ready=1: addresses SHALL go 0, 4, 8. The first capture SHALL occur 2 cycles after reset release. instr_count=3 after three accepts.
REQ-041 stall high for 3 cycles while if_instr=32'h2008_0005: if_instr, if_valid and pc SHALL hold, imem_req=0, and the count SHALL be unchanged.
REQ-042 jump=1, if_pc4=32'h4000_0010, jump_index=26'h000_0040: pc SHALL become 32'h4000_0100 and if_valid 0 next cycle. With branch_taken=1 in the same cycle, jump SHALL still win.
REQ-043 branch_taken=1, branch_target=32'h0000_0102: pc SHALL become 32'h0000_0100 and align_err SHALL be 1, remaining set after further fetches.
REQ-044 imem_ready low for 2 cycles: two bubbles (if_valid=0) and pc SHALL hold. pc=32'hFFFF_FFFC accepted SHALL wrap pc to 0.
REQ-045 halt=1 with redirect pending: state SHALL be HALTED, imem_req=0, and pc unchanged until rst.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, fetch-state encoding and reset defaults shared across the front end
package mips_pkg;
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2b;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;
  // J-type target: region bits of the delay-slot PC with the word index appended
  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction
endpackage

// File: rtl/pc_next.sv
// pc_next: sequential/branch/jump next-PC selection with jump priority and alignment check
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [3:0]  pc4_region,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_seq,
  output logic [31:0] pc_redirect,
  output logic        redirect,
  output logic        misalign
);
  // jump outranks branch; branch targets are forced to word alignment and flagged if they were not
  always_comb begin
    pc_seq      = pc + 32'd4;
    redirect    = jump | branch_taken;
    pc_redirect = jump ? jump_target(pc4_region, jump_index) : {branch_target[31:2], 2'b00};
    misalign    = branch_taken & ~jump & |branch_target[1:0];
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch FSM, program counter and IF/ID pipeline register
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        halt,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic        if_valid,
  output logic [5:0]  opcode,
  output logic [31:0] instr_count,
  output logic        align_err
);
  fetch_state_t state, state_nx;
  logic [31:0] pc, pc_seq, pc_redirect;
  logic redirect, misalign, active, take_redirect, accept, hold_ifid;

  pc_next u_pc_next (
    .pc            (pc),
    .pc4_region    (if_pc4[31:28]),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_seq        (pc_seq),
    .pc_redirect   (pc_redirect),
    .redirect      (redirect),
    .misalign      (misalign)
  );

  // halt in the same cycle as a redirect or fetch wins, so nothing moves once it is seen
  always_comb begin
    state_nx      = state == BOOT ? RUN : (state == RUN && halt) ? HALTED : state;
    active        = state == RUN && !halt;
    take_redirect = active && redirect;
    accept        = active && !stall && imem_ready && !redirect;
    hold_ifid     = active && stall && !redirect;
    imem_req      = state == RUN && !stall;
    imem_addr     = pc;
    opcode        = if_instr[31:26];
  end

  // fetch state register; HALTED only exits through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nx;
  end

  // pc, IF/ID register, fetch counter and sticky alignment flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_instr    <= '0;
      if_pc4      <= '0;
      if_valid    <= 1'b0;
      instr_count <= '0;
      align_err   <= 1'b0;
    end else begin
      if (take_redirect) pc <= pc_redirect;
      else if (accept)   pc <= pc_seq;
      if (accept) begin
        if_instr    <= imem_rdata;
        if_pc4      <= pc_seq;
        instr_count <= instr_count + 32'd1;
      end
      if_valid  <= accept || (hold_ifid && if_valid);
      align_err <= align_err || (take_redirect && misalign);
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch, stall, redirect, bubble, wrap, halt and reset
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        halt;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;
  logic [5:0]  opcode;
  logic [31:0] instr_count;
  logic        align_err;
  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .halt          (halt),
    .if_instr      (if_instr),
    .if_pc4        (if_pc4),
    .if_valid      (if_valid),
    .opcode        (opcode),
    .instr_count   (instr_count),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] addr, input logic valid, input logic [31:0] cnt);
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, valid});
    chk({tag, ".count"}, instr_count, cnt);
  endtask

  initial begin
    rst = 1'b1; imem_rdata = '0; imem_ready = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_target = '0; jump = 1'b0; jump_index = '0; halt = 1'b0;
    #1;
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.opcode", {26'd0, opcode}, 32'd0);
    chk("rst.instr", if_instr, 32'd0);
    chk("rst.pc4", if_pc4, 32'd0);
    chk("rst.align", {31'd0, align_err}, 32'd0);
    chk_regs("rst", 32'h0, 1'b0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("boot.req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("run.req", {31'd0, imem_req}, 32'd1);
    chk_regs("run", 32'h0, 1'b0, 32'd0);
    imem_rdata = 32'h2008_0005;
    tick();
    chk("f0.instr", if_instr, 32'h2008_0005);
    chk("f0.opcode", {26'd0, opcode}, 32'h08);
    chk("f0.pc4", if_pc4, 32'h4);
    chk_regs("f0", 32'h4, 1'b1, 32'd1);
    stall = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("stall.req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.instr", if_instr, 32'h2008_0005);
      chk_regs("stall", 32'h4, 1'b1, 32'd1);
    end
    stall = 1'b0; imem_rdata = 32'h8C01_0008;
    tick();
    chk_regs("f1", 32'h8, 1'b1, 32'd2);
    chk("f1.pc4", if_pc4, 32'h8);
    imem_rdata = 32'h0000_0020;
    tick();
    chk_regs("f2", 32'hC, 1'b1, 32'd3);
    chk("f2.opcode", {26'd0, opcode}, 32'h00);
    branch_taken = 1'b1; branch_target = 32'h4000_000C;
    tick();
    chk_regs("br0", 32'h4000_000C, 1'b0, 32'd3);
    chk("br0.align", {31'd0, align_err}, 32'd0);
    branch_taken = 1'b0; imem_rdata = 32'h0800_0040;
    tick();
    chk_regs("f3", 32'h4000_0010, 1'b1, 32'd4);
    chk("f3.pc4", if_pc4, 32'h4000_0010);
    jump = 1'b1; jump_index = 26'h000_0040; branch_taken = 1'b1; branch_target = 32'h0000_0203; stall = 1'b1;
    tick();
    chk_regs("jmp", 32'h4000_0100, 1'b0, 32'd4);
    chk("jmp.align", {31'd0, align_err}, 32'd0);
    jump = 1'b0; stall = 1'b0; branch_target = 32'h0000_0102; imem_ready = 1'b0;
    tick();
    chk_regs("mis", 32'h0000_0100, 1'b0, 32'd4);
    chk("mis.align", {31'd0, align_err}, 32'd1);
    branch_taken = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h1000_0003;
    tick();
    chk_regs("f4", 32'h0000_0104, 1'b1, 32'd5);
    chk("f4.instr", if_instr, 32'h1000_0003);
    chk("f4.align", {31'd0, align_err}, 32'd1);
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bub.req", {31'd0, imem_req}, 32'd1);
      tick();
      chk_regs("bub", 32'h0000_0104, 1'b0, 32'd5);
    end
    imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    chk_regs("br1", 32'hFFFF_FFFC, 1'b0, 32'd5);
    branch_taken = 1'b0; imem_rdata = 32'hAC02_0004;
    tick();
    chk_regs("wrap", 32'h0, 1'b1, 32'd6);
    chk("wrap.pc4", if_pc4, 32'h0);
    chk("wrap.opcode", {26'd0, opcode}, 32'h2B);
    imem_rdata = 32'h0000_0000;
    tick();
    chk_regs("f5", 32'h4, 1'b1, 32'd7);
    halt = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF; branch_taken = 1'b1; branch_target = 32'h0000_0800;
    tick();
    chk_regs("halt", 32'h4, 1'b0, 32'd7);
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("hlt.req", {31'd0, imem_req}, 32'd0);
      tick();
      chk_regs("hlt", 32'h4, 1'b0, 32'd7);
    end
    jump = 1'b0; branch_taken = 1'b0; imem_rdata = 32'h2008_0005;
    tick();
    chk_regs("hlt2", 32'h4, 1'b0, 32'd7);
    rst = 1'b1;
    #1;
    chk_regs("arst", 32'h0, 1'b0, 32'd0);
    chk("arst.instr", if_instr, 32'h0);
    chk("arst.align", {31'd0, align_err}, 32'd0);
    chk("arst.req", {31'd0, imem_req}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_regs("reboot", 32'h0, 1'b0, 32'd0);
    tick();
    chk_regs("refetch", 32'h4, 1'b1, 32'd1);
    chk("refetch.instr", if_instr, 32'h2008_0005);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
